// File: rtl/core_lsu_pkg.sv
// Shared encodings for the load/store pipe stage.
// Size codes, cause codes, FSM states and watchdog width helper.
package core_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_LD_MIS  = 2'd1;
    localparam logic [1:0] CAUSE_ST_MIS  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT
    } state_e;

    // Watchdog counts 0..timeout-1
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane alignment for the load/store stage.
// Store lane replication and strobes; load extract and extension.
module core_lsu_align
    import core_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [1:0]      ld_size,
    input  logic [1:0]      ld_lo,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] lane_data,
    output logic [3:0]      strb,
    output logic [XLEN-1:0] ld_value
);

    logic [3:0]      base;
    logic [XLEN-1:0] shifted;
    logic            sgn;

    always_comb begin
        lane_data = st_data;
        base      = 4'hF;
        case (st_size)
            SZ_BYTE: begin
                lane_data = {4{st_data[7:0]}};
                base      = 4'h1;
            end
            SZ_HALF: begin
                lane_data = {2{st_data[15:0]}};
                base      = 4'h3;
            end
            default: ;
        endcase
        // Shifted strobe is truncated to the 4 byte lanes
        strb = base << st_lo;
    end

    always_comb begin
        shifted  = ld_data >> {ld_lo, 3'b000};
        ld_value = shifted;
        sgn      = 1'b0;
        case (ld_size)
            SZ_BYTE: begin
                sgn      = ~ld_unsigned & shifted[7];
                ld_value = {{(XLEN-8){sgn}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sgn      = ~ld_unsigned & shifted[15];
                ld_value = {{(XLEN-16){sgn}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_pipe_lsu.sv
// Load/store pipe stage with valid/ready handshake and RAM watchdog.
// CORE_LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of issuing.
module core_pipe_lsu
    import core_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RAW     = 5,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RAW-1:0]  in_rd,
    input  logic            in_wen,
    input  logic            in_load,
    input  logic            in_store,
    input  logic            in_unsigned,
    input  logic [1:0]      in_size,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_value,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RAW-1:0]  out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_wdata,
    output logic [XLEN-1:0] out_pc,
    output logic            out_err,
    output logic [1:0]      out_cause,
    output logic            ram_req,
    output logic            ram_wen,
    output logic [XLEN-1:0] ram_addr,
    output logic [1:0]      ram_size,
    output logic [XLEN-1:0] ram_wdata,
    output logic [3:0]      ram_wstrb,
    input  logic            ram_done,
    input  logic [XLEN-1:0] ram_rdata
);

    localparam int CW = cnt_width(TIMEOUT);

    typedef struct packed {
        logic [RAW-1:0]  rd;
        logic            wen;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] pc;
        logic            err;
        logic [1:0]      cause;
    } res_t;

    state_e          state, state_nxt;
    res_t            res, hold, acc_res;
    logic [CW-1:0]   cnt;
    logic [RAW-1:0]  req_rd;
    logic [XLEN-1:0] req_pc;
    logic            req_unsigned;
    logic            accept, is_mem, trap, issue;
    logic            timeout, finish, take, park;
    logic [XLEN-1:0] lane_data, ld_value;
    logic [3:0]      strb;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_load || in_store;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
    assign trap     = is_mem && misaligned(in_size, in_addr[1:0]);
`else
    assign trap     = 1'b0;
`endif
    assign issue    = accept && is_mem && !trap;
    assign timeout  = cnt == CW'(TIMEOUT - 1);
    assign finish   = (state == ACCESS) && (ram_done || timeout);

    core_lsu_align #(.XLEN(XLEN)) u_align (
        .st_size     (in_size),
        .st_lo       (in_addr[1:0]),
        .st_data     (in_wdata),
        .ld_size     (ram_size),
        .ld_lo       (ram_addr[1:0]),
        .ld_unsigned (req_unsigned),
        .ld_data     (ram_rdata),
        .lane_data   (lane_data),
        .strb        (strb),
        .ld_value    (ld_value)
    );

    // ram_done in the timeout cycle wins
    always_comb begin
        acc_res       = '0;
        acc_res.rd    = req_rd;
        acc_res.pc    = req_pc;
        acc_res.wen   = ram_done && !ram_wen;
        acc_res.wdata = (ram_done && !ram_wen) ? ld_value : '0;
        acc_res.err   = !ram_done;
        acc_res.cause = ram_done ? CAUSE_NONE : CAUSE_TIMEOUT;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        park      = 1'b0;
        res       = '0;
        unique case (state)
            IDLE: begin
                if (accept && issue) begin
                    state_nxt = ACCESS;
                end else if (accept) begin
                    take      = 1'b1;
                    res.rd    = in_rd;
                    res.pc    = in_pc;
                    res.wen   = is_mem ? 1'b0 : in_wen;
                    res.wdata = is_mem ? '0 : in_value;
                    res.err   = is_mem;
                    res.cause = !is_mem ? CAUSE_NONE :
                                in_load ? CAUSE_LD_MIS : CAUSE_ST_MIS;
                end
            end
            ACCESS: begin
                if (finish && (!out_valid || out_ready)) begin
                    take      = 1'b1;
                    res       = acc_res;
                    state_nxt = IDLE;
                end else if (finish) begin
                    park      = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (out_ready) begin
                    take      = 1'b1;
                    res       = hold;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
            out_wdata <= '0;
            out_pc    <= '0;
            out_err   <= 1'b0;
            out_cause <= CAUSE_NONE;
            hold      <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_rd    <= res.rd;
                out_wen   <= res.wen;
                out_wdata <= res.wdata;
                out_pc    <= res.pc;
                out_err   <= res.err;
                out_cause <= res.cause;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (park) hold <= acc_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_req      <= 1'b0;
            ram_wen      <= 1'b0;
            ram_addr     <= '0;
            ram_size     <= '0;
            ram_wdata    <= '0;
            ram_wstrb    <= '0;
            req_rd       <= '0;
            req_pc       <= '0;
            req_unsigned <= 1'b0;
            cnt          <= '0;
        end else if (issue) begin
            ram_req      <= 1'b1;
            ram_wen      <= in_store && !in_load;
            ram_addr     <= in_addr;
            ram_size     <= in_size;
            ram_wdata    <= lane_data;
            ram_wstrb    <= (in_store && !in_load) ? strb : 4'h0;
            req_rd       <= in_rd;
            req_pc       <= in_pc;
            req_unsigned <= in_unsigned;
            cnt          <= '0;
        end else if (finish) begin
            ram_req <= 1'b0;
        end else if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_core_pipe_lsu.sv
// Scoreboard bench for core_pipe_lsu (TIMEOUT=8).
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_core_pipe_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_wen = 1'b0;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic        in_unsigned = 1'b0;
    logic [1:0]  in_size = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [31:0] in_value = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_wdata;
    logic [31:0] out_pc;
    logic        out_err;
    logic [1:0]  out_cause;
    logic        ram_req;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [1:0]  ram_size;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic        ram_done = 1'b0;
    logic [31:0] ram_rdata = '0;

    core_pipe_lsu #(.XLEN(32), .RAW(5), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wen(in_wen),
        .in_load(in_load), .in_store(in_store),
        .in_unsigned(in_unsigned), .in_size(in_size),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_value(in_value), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_wen(out_wen),
        .out_wdata(out_wdata), .out_pc(out_pc),
        .out_err(out_err), .out_cause(out_cause),
        .ram_req(ram_req), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_size(ram_size),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
        .ram_done(ram_done), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        err;
        logic [1:0]  cause;
        bit          chk;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic [31:0] pc_ctr = 32'h1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic wen,
                                input logic [31:0] wdata,
                                input logic [31:0] pc, input logic err,
                                input logic [1:0] cause, input bit chk);
        exp_t e;
        e.rd = rd; e.wen = wen; e.wdata = wdata; e.pc = pc;
        e.err = err; e.cause = cause; e.chk = chk;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_rd", 32'(out_rd), 32'(e.rd));
                check("out_pc", out_pc, e.pc);
                check("out_wen", 32'(out_wen), 32'(e.wen));
                check("out_err", 32'(out_err), 32'(e.err));
                check("out_cause", 32'(out_cause), 32'(e.cause));
                if (e.chk) check("out_wdata", out_wdata, e.wdata);
            end
        end
    end

    // Presents one op and returns at posedge+1 of the cycle after accept
    task automatic send(input logic ld, input logic st, input logic uns,
                        input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] val,
                        input logic [4:0] rd, input logic wen,
                        input exp_t e);
        bit got = 0;
        q.push_back(e);
        in_load = ld; in_store = st; in_unsigned = uns;
        in_size = sz; in_addr = addr; in_wdata = wd;
        in_value = val; in_rd = rd; in_wen = wen;
        in_pc = e.pc; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        pc_ctr = pc_ctr + 4;
    endtask

    task automatic respond(input int k, input logic [31:0] rdata);
        int held = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (ram_req) held++;
            @(posedge clk); #1;
        end
        check("ram_req_stable", 32'(held), 32'(k));
        ram_rdata = rdata;
        ram_done = 1'b1;
        @(posedge clk); #1;
        ram_done = 1'b0;
        check("ram_req_drop", 32'(ram_req), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] want;
        int          k;
    } ld_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [31:0] lane;
        logic [3:0]  strb;
    } st_vec_t;

    ld_vec_t lds[8] = '{
        '{32'h103, 2'd0, 1'b0, 32'hFFFF_FF80, 3},
        '{32'h103, 2'd0, 1'b1, 32'h0000_0080, 3},
        '{32'h102, 2'd1, 1'b0, 32'hFFFF_80FF, 0},
        '{32'h102, 2'd1, 1'b1, 32'h0000_80FF, 1},
        '{32'h100, 2'd2, 1'b0, 32'h80FF_FF7F, 2},
        '{32'h100, 2'd0, 1'b0, 32'h0000_007F, 0},
        '{32'h100, 2'd1, 1'b0, 32'hFFFF_FF7F, 1},
        '{32'h101, 2'd0, 1'b1, 32'h0000_00FF, 0}
    };

    st_vec_t sts[5] = '{
        '{32'h202, 2'd1, 32'h0000_ABCD, 32'hABCD_ABCD, 4'hC},
        '{32'h201, 2'd0, 32'h0000_005A, 32'h5A5A_5A5A, 4'h2},
        '{32'h200, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF},
        '{32'h200, 2'd1, 32'h9999_1234, 32'h1234_1234, 4'h3},
        '{32'h203, 2'd0, 32'h0000_00C3, 32'hC3C3_C3C3, 4'h8}
    };

    initial begin
        int t0;
        int n;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ram_req", 32'(ram_req), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU ops back to back
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            v = 32'h1234 + 32'(i);
            send(0, 0, 0, 2'd0, '0, '0, v, 5'(i + 1), 1'b1,
                 mk(5'(i + 1), 1'b1, v, pc_ctr, 0, 2'd0, 1));
        end
        check("alu_no_bubble", 32'(cyc - t0), 32'd4);

        foreach (lds[i]) begin
            send(1, 0, lds[i].uns, lds[i].sz, lds[i].addr, '0, '0,
                 5'd7, 1'b0, mk(5'd7, 1'b1, lds[i].want, pc_ctr, 0, 2'd0, 1));
            check("ld_in_ready_busy", 32'(in_ready), 32'd0);
            check("ld_ram_addr", ram_addr, lds[i].addr);
            check("ld_wstrb", 32'(ram_wstrb), 32'd0);
            respond(lds[i].k, 32'h80FF_FF7F);
        end

        foreach (sts[i]) begin
            send(0, 1, 0, sts[i].sz, sts[i].addr, sts[i].wd, '0,
                 5'd9, 1'b1, mk(5'd9, 1'b0, '0, pc_ctr, 0, 2'd0, 0));
            check("st_ram_wen", 32'(ram_wen), 32'd1);
            check("st_ram_wdata", ram_wdata, sts[i].lane);
            check("st_ram_wstrb", 32'(ram_wstrb), 32'(sts[i].strb));
            check("st_ram_size", 32'(ram_size), 32'(sts[i].sz));
            respond(i % 3, 32'h0);
        end

        // Result held while downstream stalls
        send(1, 0, 0, 2'd2, 32'h104, '0, '0, 5'd11, 1'b0,
             mk(5'd11, 1'b1, 32'hCAFE_F00D, pc_ctr, 0, 2'd0, 1));
        out_ready = 1'b0;
        respond(0, 32'hCAFE_F00D);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid && !in_ready && out_wdata == 32'hCAFE_F00D) n++;
            @(posedge clk); #1;
        end
        check("stall_hold", 32'(n), 32'd5);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Watchdog abort
        send(1, 0, 0, 2'd2, 32'h300, '0, '0, 5'd12, 1'b0,
             mk(5'd12, 1'b0, '0, pc_ctr, 1, 2'd3, 0));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!ram_req) break;
            n++;
            @(posedge clk); #1;
        end
        check("timeout_req_cycles", 32'(n), 32'd8);
        @(posedge clk); #1;

`ifdef CORE_LSU_MISALIGN_TRAP_EN
        send(1, 0, 0, 2'd2, 32'h2, '0, '0, 5'd13, 1'b0,
             mk(5'd13, 1'b0, '0, pc_ctr, 1, 2'd1, 0));
        check("mis_ld_no_req", 32'(ram_req), 32'd0);
        send(0, 1, 0, 2'd1, 32'h1, '0, '0, 5'd14, 1'b0,
             mk(5'd14, 1'b0, '0, pc_ctr, 1, 2'd2, 0));
        check("mis_st_no_req", 32'(ram_req), 32'd0);
        @(posedge clk); #1;
`else
        send(1, 0, 0, 2'd2, 32'h2, '0, '0, 5'd13, 1'b0,
             mk(5'd13, 1'b1, '0, pc_ctr, 0, 2'd0, 0));
        check("mis_ld_req", 32'(ram_req), 32'd1);
        respond(0, 32'h1122_3344);
`endif

        // Reset during an access abandons it
        send(1, 0, 0, 2'd2, 32'h400, '0, '0, 5'd15, 1'b0,
             mk(5'd15, 1'b1, '0, pc_ctr, 0, 2'd0, 0));
        void'(q.pop_back());
        check("mid_req_on", 32'(ram_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(ram_req), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(0, 0, 0, 2'd0, '0, '0, 32'h55AA, 5'd2, 1'b1,
             mk(5'd2, 1'b1, 32'h55AA, pc_ctr, 0, 2'd0, 1));

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
